// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM states and sync-character measurement constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_IDLE  = 3'd1,
        WAIT_START = 3'd2,
        MEASURE    = 3'd3,
        WAIT_STOP  = 3'd4,
        LOCKED     = 3'd5
    } autobaud_state_t;

    localparam logic [7:0] SYNC_CHAR = 8'h55;
    localparam int         EDGES     = 4;
    localparam int         ROUND     = 32;
    localparam int         SHIFT     = 6;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial line with registered rise/fall flags.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic s,
    output logic s_d,
    output logic fall,
    output logic rise
);

    logic meta_r;

    // Edge flags are computed from the values s/s_d take on this edge, so they match s_d & ~s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b1;
            s      <= 1'b1;
            s_d    <= 1'b1;
            fall   <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta_r <= rxd;
            s      <= meta_r;
            s_d    <= s;
            fall   <= s & ~meta_r;
            rise   <= ~s & meta_r;
        end
    end

endmodule

// File: rtl/uart_autobaud.sv
// Autobaud controller: measures one 0x55 sync character and produces a locked uart_rx prescale.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int CNT_WIDTH   = 22,
    parameter int IDLE_CYCLES = 1024,
    parameter int TOL_SHIFT   = 2,
    parameter int AUTO_RETRY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rxd,
    output logic [15:0] prescale,
    output logic        locked,
    output logic        rx_hold,
    output logic        busy,
    output logic        error
);

    localparam int IW  = $clog2(IDLE_CYCLES + 1);
    localparam int CW1 = CNT_WIDTH + 1;
    localparam int CW2 = CNT_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam autobaud_state_t RETRY_STATE = (AUTO_RETRY != 0) ? WAIT_IDLE : IDLE;

    logic s, s_d, fall, rise;

    autobaud_state_t state_r, fsm_next_s, next_state_s;
    logic [IW-1:0]        idle_cnt_r;
    logic [CNT_WIDTH-1:0] icnt_r, total_r, i0_r;
    logic [2:0]           k_r;

    logic [CW1-1:0] ik_s, tol_s, diff_s, absdiff_s, limit_s;
    logic [CW2-1:0] sum_s, rnd_s, pre_s;
    logic           pre_bad_s, err_s;
    logic           idle_clr_s, idle_inc_s, meas_init_s, cnt_inc_s, edge_acc_s, load_pre_s;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .s    (s),
        .s_d  (s_d),
        .fall (fall),
        .rise (rise)
    );

    assign ik_s      = {1'b0, icnt_r} + CW1'(1);
    assign tol_s     = {1'b0, (i0_r >> TOL_SHIFT)};
    assign diff_s    = ik_s - {1'b0, i0_r};
    assign absdiff_s = diff_s[CNT_WIDTH] ? (~diff_s + CW1'(1)) : diff_s;
    assign limit_s   = {1'b0, i0_r} + tol_s;
    assign sum_s     = {2'b00, total_r} + {1'b0, ik_s};
    assign rnd_s     = {2'b00, total_r} + CW2'(ROUND);
    assign pre_s     = rnd_s >> SHIFT;
    assign pre_bad_s = (pre_s == CW2'(0)) || (pre_s > CW2'(16'hFFFF));

    assign next_state_s = err_s ? RETRY_STATE : fsm_next_s;

    // Next-state and datapath control decode.
    always_comb begin
        fsm_next_s  = state_r;
        err_s       = 1'b0;
        idle_clr_s  = 1'b0;
        idle_inc_s  = 1'b0;
        meas_init_s = 1'b0;
        cnt_inc_s   = 1'b0;
        edge_acc_s  = 1'b0;
        load_pre_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    fsm_next_s = WAIT_IDLE;
                    idle_clr_s = 1'b1;
                end else begin
                    fsm_next_s = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!s) begin
                    idle_clr_s = 1'b1;
                end else if ((idle_cnt_r == IW'(IDLE_CYCLES - 1)) && s_d) begin
                    fsm_next_s = WAIT_START;
                end else begin
                    idle_inc_s = 1'b1;
                end
            end
            WAIT_START: begin
                if (fall) begin
                    fsm_next_s  = MEASURE;
                    meas_init_s = 1'b1;
                end else begin
                    fsm_next_s = WAIT_START;
                end
            end
            MEASURE: begin
                // An edge wins over any overflow seen in the same cycle.
                if (fall) begin
                    if ((k_r != 3'd0) && (absdiff_s > tol_s)) begin
                        err_s = 1'b1;
                    end else if (sum_s[CW2-1:CNT_WIDTH] != 2'b00) begin
                        err_s = 1'b1;
                    end else begin
                        edge_acc_s = 1'b1;
                        fsm_next_s = (k_r == 3'(EDGES - 1)) ? WAIT_STOP : MEASURE;
                    end
                end else if (k_r == 3'd0) begin
                    err_s     = (icnt_r == CNT_MAX);
                    cnt_inc_s = (icnt_r != CNT_MAX);
                end else begin
                    err_s     = ({1'b0, icnt_r} > limit_s);
                    cnt_inc_s = ({1'b0, icnt_r} <= limit_s);
                end
            end
            WAIT_STOP: begin
                if (rise) begin
                    err_s      = pre_bad_s;
                    load_pre_s = !pre_bad_s;
                    fsm_next_s = LOCKED;
                end else if (icnt_r >= i0_r) begin
                    err_s = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            LOCKED: begin
                if (start) begin
                    fsm_next_s = WAIT_IDLE;
                    idle_clr_s = 1'b1;
                end else begin
                    fsm_next_s = LOCKED;
                end
            end
            default: begin
                fsm_next_s = IDLE;
            end
        endcase
    end

    // Measurement counters; the interval counter is reused as the stop-bit timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_r <= '0;
            icnt_r     <= '0;
            total_r    <= '0;
            i0_r       <= '0;
            k_r        <= 3'd0;
        end else begin
            if (idle_clr_s || err_s) begin
                idle_cnt_r <= '0;
            end else if (idle_inc_s) begin
                idle_cnt_r <= idle_cnt_r + IW'(1);
            end
            if (meas_init_s) begin
                icnt_r  <= '0;
                total_r <= '0;
                k_r     <= 3'd0;
            end else if (edge_acc_s) begin
                icnt_r  <= '0;
                total_r <= sum_s[CNT_WIDTH-1:0];
                k_r     <= k_r + 3'd1;
                if (k_r == 3'd0) begin
                    i0_r <= ik_s[CNT_WIDTH-1:0];
                end
            end else if (cnt_inc_s) begin
                icnt_r <= icnt_r + CNT_ONE;
            end
        end
    end

    // State and registered outputs, all taken from the next state so they change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            prescale <= 16'd0;
            locked   <= 1'b0;
            rx_hold  <= 1'b1;
            busy     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            locked  <= (next_state_s == LOCKED);
            rx_hold <= (next_state_s != LOCKED);
            busy    <= (next_state_s != IDLE) && (next_state_s != LOCKED);
            error   <= err_s;
            if (load_pre_s) begin
                prescale <= pre_s[15:0];
            end
        end
    end

endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Autobaud controller that sets up `uart_rx`. On request, it waits for an idle line, measures one 0x55 sync character on `rxd`, and computes the 16-bit `prescale` word (bit time / 8 clocks). It holds the receiver off during measurement, then releases it with a locked, stable prescale. It sits between the pad-side `rxd` and the `uart_rx` instance, and drives that instance's `prescale` port and its reset/hold.

## Interface
- `CNT_WIDTH`, 22: width of the cycle counters. The maximum measurable 8-bit span is 2^CNT_WIDTH-1 clocks.
- `IDLE_CYCLES`, 1024: number of consecutive synchronized-high cycles required before arming.
- `TOL_SHIFT`, 2: interval tolerance is I0 >> TOL_SHIFT.
- `AUTO_RETRY`, 1: 1 = return to WAIT_IDLE after an error; 0 = return to IDLE.
- `clk`, in, 1: clock. One clock domain.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `start`, in, 1: one-cycle request to (re)measure.
- `rxd`, in, 1: raw serial line (asynchronous).
- `prescale`, out, 16: value for the `uart_rx` prescale port.
- `locked`, out, 1: prescale is valid and stable.
- `rx_hold`, out, 1: drives `uart_rx` rst while high. Equals ~locked.
- `busy`, out, 1: measurement in progress (any state except IDLE and LOCKED).
- `error`, out, 1: one-cycle pulse when a measurement is rejected.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1) into `s`, plus a delayed copy `s_d`.
  - fall = s_d & ~s
  - rise = ~s_d & s
- States:
  - **IDLE**: `start` -> WAIT_IDLE.
  - **WAIT_IDLE**: idle counter increments while s=1 and clears on s=0. Reaching IDLE_CYCLES -> WAIT_START.
  - **WAIT_START**: fall -> MEASURE. On that cycle: edge index k=0, interval counter=0, total=0.
  - **MEASURE**: both counters increment every cycle. On fall with k<4:
    - Ik = interval counter + 1; total accumulates.
    - k=0 stores I0. For k>0, reject if |Ik-I0| > (I0>>TOL_SHIFT).
    - The interval counter restarts.
    - After the 4th accepted interval -> WAIT_STOP.
  - **WAIT_STOP**: rise within I0 cycles of entry -> compute prescale = (total+32)>>6 -> LOCKED. Timeout -> error.
  - **LOCKED**: `locked`=1 and `prescale` held. `start` -> WAIT_IDLE, `locked` drops the next cycle.
- Error conditions (each gives an `error` pulse, then WAIT_IDLE or IDLE per AUTO_RETRY):
  - an interval is out of tolerance;
  - interval counter exceeds I0+(I0>>TOL_SHIFT) with k>0 (missing edge);
  - interval counter saturates during I0;
  - total would wrap;
  - computed prescale is 0 or exceeds 0xFFFF;
  - WAIT_STOP timeout.
- On error, `prescale` keeps its previous value and `locked`=0.
- `start` is ignored in WAIT_IDLE, WAIT_START, MEASURE and WAIT_STOP.
- Arithmetic:
  - counters and total are unsigned CNT_WIDTH bits;
  - tolerance compare is unsigned, computed with a CNT_WIDTH+1 bit difference;
  - rounding adds 32 before the >>6.

## Timing
- Reset values: `prescale`=0, `locked`=0, `rx_hold`=1, `busy`=0, `error`=0, state IDLE. Synchronizer flops reset to 1.
- Reset asserted mid-measurement aborts immediately to these values. No `error` pulse is produced.
- Synchronizer latency is 2 cycles. It is identical for every edge, so it cancels out of all intervals.
- `start` sampled in IDLE -> `busy`=1 the next cycle.
- Rise accepted in WAIT_STOP -> `prescale` and `locked` update together 1 cycle later. `rx_hold` falls on the same edge as `locked` rises.
- `error` is registered: high exactly one cycle, concurrent with `busy` returning low (AUTO_RETRY=0) or staying high (AUTO_RETRY=1).
- fall and counter overflow in the same cycle: the edge takes priority.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, WAIT_IDLE, WAIT_START, MEASURE, WAIT_STOP, LOCKED);
  - SYNC_CHAR = 8'h55;
  - EDGES = 4;
  - ROUND = 32;
  - SHIFT = 6.
- One sub-module, `uart_rx_sync`: 2-flop synchronizer plus rise/fall detector. Reused by other UART blocks.

## Test plan
- 0x55 at 80 clocks/bit after 1100 idle cycles, `start` pulsed -> `prescale`=10, `locked`=1, `rx_hold`=0, no `error`.
- 0x55 at 87 clocks/bit -> total=696, `prescale`=11. Then a following 0x41 at the same rate, sent through `uart_rx` -> tdata=0x41.
- 0x0F at 80 clocks/bit -> I0=400 cycles. `error` pulses 501 cycles after the second fall window opens, then re-arms in WAIT_IDLE (AUTO_RETRY=1).
- Line toggling before IDLE_CYCLES is reached (low pulse every 500 cycles) -> remains in WAIT_IDLE, `busy`=1, no `locked`.
- `rst` asserted during MEASURE -> all outputs take their reset values on the next observation. Re-`start` with a clean 0x55 at 80 clocks/bit -> `prescale`=10.
- LOCKED with `prescale`=10, then `start` and 0x55 at 160 clocks/bit -> `locked` drops for the measurement, then `prescale`=20 and `locked`=1.
